// File: rtl/ndata_typed_arbiter_pkg.sv
// Shared types for the typed ndata arbiter: element type token, element data,
// arbiter state encoding and grant-width helper.
package ndata_typed_arbiter_pkg;

  typedef enum logic {TYPE_32 = 1'b0, TYPE_64 = 1'b1} type_t;
  typedef logic [63:0] data_t;

  localparam int TYPE_WIDTH = $bits(type_t);
  localparam int DATA_WIDTH = $bits(data_t);

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  function automatic int GET_TYPE_WIDTH(type_t t);
    return (t == TYPE_64) ? 64 : 32;
  endfunction

  // Grant index width; a single-requester build still needs one bit.
  function automatic int grant_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ndata_typed_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
// Reusable by any arbiter that keeps its own priority pointer.
module ndata_typed_arbiter_rr_select
  import ndata_typed_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int W = grant_width(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  int cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && elig[cand[W-1:0]]) begin
        found = 1'b1;
        index = W'(cand);
      end
    end
  end

endmodule

// File: rtl/ndata_typed_arbiter.sv
// Packet-level round-robin arbiter muxing NUM_REQUESTERS typed ndata streams
// into one downstream adapter; the grant is locked from first beat to last.
module ndata_typed_arbiter
  import ndata_typed_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int NUM_ELEMENTS   = 4,
  localparam int GW = grant_width(NUM_REQUESTERS),
  localparam int BW = NUM_ELEMENTS * DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQUESTERS-1:0]            in_type_valid,
  output logic [NUM_REQUESTERS-1:0]            in_type_ready,
  input  logic [NUM_REQUESTERS*TYPE_WIDTH-1:0] in_type_data,
  input  logic [NUM_REQUESTERS-1:0]            in_valid,
  output logic [NUM_REQUESTERS-1:0]            in_ready,
  input  logic [NUM_REQUESTERS-1:0]            in_last,
  input  logic [NUM_REQUESTERS*NUM_ELEMENTS-1:0] in_keep,
  input  logic [NUM_REQUESTERS*BW-1:0]         in_data,
  output logic                                 out_type_valid,
  input  logic                                 out_type_ready,
  output logic [TYPE_WIDTH-1:0]                out_type_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [NUM_ELEMENTS-1:0]              out_keep,
  output logic [BW-1:0]                        out_data,
  output logic [GW-1:0]                        grant,
  output logic                                 busy,
  output logic [31:0]                          pkt_count
);

  logic [TYPE_WIDTH-1:0]   req_type [NUM_REQUESTERS];
  logic [NUM_ELEMENTS-1:0] req_keep [NUM_REQUESTERS];
  logic [BW-1:0]           req_data [NUM_REQUESTERS];

  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
    assign req_type[i] = in_type_data[i*TYPE_WIDTH +: TYPE_WIDTH];
    assign req_keep[i] = in_keep[i*NUM_ELEMENTS +: NUM_ELEMENTS];
    assign req_data[i] = in_data[i*BW +: BW];
  end

  arb_state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  type_t         type_q, type_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [NUM_REQUESTERS-1:0] elig;
  logic                      sel_found;
  logic [GW-1:0]             sel_index;
  logic                      is_busy;
  logic                      pkt_done;

  assign elig    = in_type_valid & in_valid;
  assign is_busy = (state_q == ARB_BUSY);

  ndata_typed_arbiter_rr_select #(.N(NUM_REQUESTERS)) u_rr_select (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (sel_found),
    .index (sel_index)
  );

  // Zero-latency datapath: while BUSY the granted stream passes straight through.
  always_comb begin
    out_valid      = 1'b0;
    out_last       = 1'b0;
    out_keep       = '0;
    out_data       = '0;
    out_type_valid = 1'b0;
    out_type_data  = '0;
    in_ready       = '0;
    in_type_ready  = '0;
    if (is_busy) begin
      out_valid               = in_valid[grant_q];
      out_last                = in_last[grant_q];
      out_keep                = req_keep[grant_q];
      out_data                = req_data[grant_q];
      out_type_valid          = 1'b1;
      out_type_data           = type_q;
      in_ready[grant_q]       = out_ready;
      in_type_ready[grant_q]  = out_type_ready;
    end
  end

  assign pkt_done = is_busy && out_valid && out_ready && out_last;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          grant_d = sel_index;
          type_d  = type_t'(req_type[sel_index]);
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Winner becomes lowest priority for the next arbitration.
        if (pkt_done) begin
          ptr_d   = grant_q;
          cnt_d   = cnt_q + 32'd1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d == ARB_BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_REQUESTERS - 1);
      type_q  <= TYPE_32;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_ndata_typed_arbiter.sv
// Randomized self-checking bench for ndata_typed_arbiter (4 requesters),
// compared every cycle against a packet-level reference model.
module tb_ndata_typed_arbiter;
  import ndata_typed_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int E  = 4;
  localparam int BW = E * DATA_WIDTH;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      in_type_valid = '0;
  logic [N-1:0]      in_type_ready;
  logic [N-1:0]      in_type_data = '0;
  logic [N-1:0]      in_valid = '0;
  logic [N-1:0]      in_ready;
  logic [N-1:0]      in_last = '0;
  logic [N*E-1:0]    in_keep = '0;
  logic [N*BW-1:0]   in_data = '0;
  logic              out_type_valid;
  logic              out_type_ready;
  logic [0:0]        out_type_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic [E-1:0]      out_keep;
  logic [BW-1:0]     out_data;
  logic [GW-1:0]     grant;
  logic              busy;
  logic [31:0]       pkt_count;

  ndata_typed_arbiter #(.NUM_REQUESTERS(N), .NUM_ELEMENTS(E)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_type_valid(in_type_valid), .in_type_ready(in_type_ready), .in_type_data(in_type_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_keep(in_keep), .in_data(in_data),
    .out_type_valid(out_type_valid), .out_type_ready(out_type_ready), .out_type_data(out_type_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_keep(out_keep), .out_data(out_data),
    .grant(grant), .busy(busy), .pkt_count(pkt_count)
  );

  // The adapter only accepts the type token together with the final beat.
  assign out_type_ready = out_ready & out_valid & out_last;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Producer side (what the bench drives) and model side (what it expects).
  logic [N-1:0] active;
  int len    [N];
  int p_beat [N];
  int p_pkt  [N];
  int m_beat [N];
  int m_pkt  [N];
  int valid_pct;
  int ready_pct;
  bit          m_busy;
  int          m_grant;
  int          m_ptr;
  type_t       m_type;
  logic [31:0] m_count;
  int          seq[$];

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic type_t type_of(int r);
    return (r % 2 == 1) ? TYPE_64 : TYPE_32;
  endfunction

  function automatic logic [BW-1:0] enc(int r, int pkt, int beat);
    logic [BW-1:0] v;
    for (int e = 0; e < E; e++)
      v[e*64 +: 64] = {8'(r), 16'(pkt), 8'(beat), 8'(e), 24'h5A3C96};
    return v;
  endfunction

  function automatic logic [E-1:0] keep_of(int beat, int plen);
    return (beat == plen - 1) ? 4'b0011 : 4'b1111;
  endfunction

  task automatic resetModel();
    m_busy  = 1'b0;
    m_grant = 0;
    m_ptr   = N - 1;
    m_type  = TYPE_32;
    m_count = '0;
    for (int r = 0; r < N; r++) begin
      p_beat[r] = 0;
      m_beat[r] = 0;
    end
  endtask

  task automatic driveInputs();
    for (int r = 0; r < N; r++) begin
      in_valid[r]      = active[r] && ($urandom_range(99) < valid_pct);
      in_type_valid[r] = active[r];
      in_type_data[r]  = type_of(r);
      in_last[r]       = (p_beat[r] == len[r] - 1);
      in_keep[r*E +: E]   = keep_of(p_beat[r], len[r]);
      in_data[r*BW +: BW] = enc(r, p_pkt[r], p_beat[r]);
    end
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic checkResetState();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_count", pkt_count, 0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_type_valid", out_type_valid, 1'b0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_type_ready", in_type_ready, 0);
  endtask

  // Asynchronous reset: outputs are checked before any clock edge.
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkResetState();
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    driveInputs();
    rst_n = 1'b1;
  endtask

  // Compare DUT against the model for this cycle, then advance both sides.
  task automatic checkCycle();
    logic [N-1:0] exp_ir, exp_itr;
    bit exp_ov;
    int g, best, bestd, d;
    g = m_grant;
    exp_ov = 1'b0; exp_ir = '0; exp_itr = '0;
    if (m_busy) begin
      exp_ov = in_valid[g];
      if (out_ready) exp_ir = 4'(1) << g;
      if (out_ready && in_valid[g] && (m_beat[g] == len[g] - 1)) exp_itr = 4'(1) << g;
    end
    checkOutput("busy", busy, m_busy);
    checkOutput("grant", grant, m_grant);
    checkOutput("pkt_count", pkt_count, m_count);
    checkOutput("out_valid", out_valid, exp_ov);
    checkOutput("type_valid", out_type_valid, m_busy);
    checkOutput("in_ready", in_ready, exp_ir);
    checkOutput("type_ready", in_type_ready, exp_itr);
    if (m_busy) begin
      checkOutput("type_data", out_type_data, m_type);
      if (exp_ov) begin
        checkOutput("out_data", out_data, enc(g, m_pkt[g], m_beat[g]));
        checkOutput("out_keep", out_keep, keep_of(m_beat[g], len[g]));
        checkOutput("out_last", out_last, m_beat[g] == len[g] - 1);
      end
    end
    if (out_valid && out_ready && out_last) seq.push_back(int'(grant));
    for (int r = 0; r < N; r++) begin
      if (in_valid[r] && in_ready[r]) begin
        if (in_last[r]) begin p_beat[r] = 0; p_pkt[r]++; end
        else p_beat[r]++;
      end
    end
    if (!m_busy) begin
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr - 1 + 2 * N) % N;
        if (in_valid[i] && in_type_valid[i] && d < bestd) begin bestd = d; best = i; end
      end
      if (best >= 0) begin
        m_busy = 1'b1; m_grant = best; m_type = type_of(best);
      end
    end else if (in_valid[g] && out_ready) begin
      if (m_beat[g] == len[g] - 1) begin
        m_beat[g] = 0; m_pkt[g]++; m_ptr = g; m_count = m_count + 32'd1; m_busy = 1'b0;
      end else begin
        m_beat[g]++;
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    #1;
    driveInputs();
  endtask

  // plen == 0 picks a random packet length per requester.
  task automatic applyStimulus(input logic [N-1:0] act, input int plen, input int vpct,
                               input int rpct, input int cycles);
    active = act; valid_pct = vpct; ready_pct = rpct;
    for (int r = 0; r < N; r++) len[r] = (plen == 0) ? int'($urandom_range(1, 5)) : plen;
    applyReset();
    seq.delete();
    repeat (cycles) stepCycle();
  endtask

  task automatic checkSeq(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_s[4];
    exp_s = '{e0, e1, e2, e3};
    checkOutput({tag, "_len"}, seq.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      checkOutput(tag, (seq.size() > k) ? seq[k] : 'hff, exp_s[k]);
  endtask

  initial begin
    int waited;
    for (int r = 0; r < N; r++) begin p_pkt[r] = 0; m_pkt[r] = 0; len[r] = 1; end
    active = '0; valid_pct = 0; ready_pct = 0;
    #2;
    applyStimulus(4'b0011, 3, 100, 100, 40);
    checkSeq("rr_pair", 0, 1, 0, 1);
    applyStimulus(4'b0111, 4, 80, 40, 300);
    applyStimulus(4'b1100, 1, 100, 100, 20);
    checkSeq("single", 2, 3, 2, 3);
    applyStimulus(4'b1111, 0, 70, 70, 600);
    applyStimulus(4'b1111, 4, 100, 100, 0);
    waited = 0;
    while (!(m_busy && p_beat[m_grant] == 1 && m_count != 0) && waited < 100) begin
      stepCycle();
      waited++;
    end
    checkOutput("midpkt_wait", waited < 100, 1'b1);
    #2;
    applyReset();
    seq.delete();
    repeat (30) stepCycle();
    checkSeq("after_rst", 0, 1, 2, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
